// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer: prescaled rotate/ping-pong/fill patterns with run/pause/step.
// Optional build macro LED_SEQ_PWM_EN adds a 4-bit brightness input and a PWM output stage.
module led_sequencer #(
  parameter int unsigned LED_NUM    = 4,
  parameter logic [24:0] CNT_MAX    = 25'd24_999_999,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               mode_load,
  input  logic               run,
  input  logic               step,
`ifdef LED_SEQ_PWM_EN
  input  logic [3:0]         bright,
`endif
  output logic [LED_NUM-1:0] led_out,
  output logic               tick_o
);

  typedef enum logic [1:0] {
    MODE_ROT_L = 2'b00,
    MODE_ROT_R = 2'b01,
    MODE_PING  = 2'b10,
    MODE_FILL  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [LED_NUM-1:0] PAT_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] PAT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] LED_RST = ACTIVE_LOW ? ~PAT_LSB : PAT_LSB;

  logic [24:0]        cnt_q, cnt_d;
  logic               tick_q, tick_d;
  mode_e              mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic [LED_NUM-1:0] pat_q, pat_d;
  logic [LED_NUM-1:0] led_q;
  logic               cnt_wrap;
  logic               advance;
  logic               pat_onehot;

  function automatic logic [LED_NUM-1:0] start_pat(input mode_e m);
    logic [LED_NUM-1:0] p;
    p = PAT_LSB;
    case (m)
      MODE_ROT_R: p = PAT_MSB;
      MODE_FILL:  p = '0;
      default:    p = PAT_LSB;
    endcase
    return p;
  endfunction

  assign cnt_wrap   = (cnt_q == CNT_MAX);
  // Single-step only counts while paused; a running sequencer ignores it.
  assign advance    = tick_q | (step & ~run);
  assign pat_onehot = (pat_q != '0) && ((pat_q & (pat_q - PAT_LSB)) == '0);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      mode_q <= MODE_ROT_L;
      dir_q  <= DIR_UP;
      pat_q  <= PAT_LSB;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    if (mode_load) begin
      mode_d = mode_e'(mode);
      pat_d  = start_pat(mode_e'(mode));
      cnt_d  = '0;
      dir_d  = DIR_UP;
    end else begin
      if (run) begin
        cnt_d  = cnt_wrap ? '0 : cnt_q + 25'd1;
        tick_d = cnt_wrap;
      end
      if (advance) begin
        case (mode_q)
          MODE_ROT_L: begin
            if (!pat_onehot) pat_d = PAT_LSB;
            else             pat_d = {pat_q[LED_NUM-2:0], pat_q[LED_NUM-1]};
          end
          MODE_ROT_R: begin
            if (!pat_onehot) pat_d = PAT_MSB;
            else             pat_d = {pat_q[0], pat_q[LED_NUM-1:1]};
          end
          MODE_PING: begin
            // Direction flips on the step that leaves an end, so end LEDs never show twice in a row.
            if (!pat_onehot) begin
              pat_d = PAT_LSB;
              dir_d = DIR_UP;
            end else if (dir_q == DIR_UP) begin
              if (pat_q[LED_NUM-1]) begin
                dir_d = DIR_DOWN;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = DIR_UP;
                pat_d = pat_q << 1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          default: begin
            if (&pat_q) pat_d = '0;
            else        pat_d = {pat_q[LED_NUM-2:0], 1'b1};
          end
        endcase
      end
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [3:0]         pwm_cnt_q;
  logic [LED_NUM-1:0] lit;

  // Lit LEDs are gated by the duty window; dark LEDs stay dark regardless of brightness.
  assign lit = pat_q & {LED_NUM{pwm_cnt_q < bright}};

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      led_q     <= LED_RST;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= ACTIVE_LOW ? ~lit : lit;
    end
  end
`else
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) led_q <= LED_RST;
    else        led_q <= ACTIVE_LOW ? ~pat_d : pat_d;
  end
`endif

  assign led_out = led_q;
  assign tick_o  = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - self-checking bench for led_sequencer (N=4, CNT_MAX=9, both polarities).
module tb_led_sequencer;

  localparam int N  = 4;
  localparam int CM = 9;

  logic         clk_50M = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         mode_load = 1'b0;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic [N-1:0] led_al, led_ah;
  logic         tick_al, tick_ah;
`ifdef LED_SEQ_PWM_EN
  logic [3:0]   bright = 4'd15;
`endif

  always #10 clk_50M = ~clk_50M;

  led_sequencer #(.LED_NUM(N), .CNT_MAX(25'd9), .ACTIVE_LOW(1'b1)) dut_al (
    .clk_50M(clk_50M), .rst_n(rst_n), .mode(mode), .mode_load(mode_load),
    .run(run), .step(step),
`ifdef LED_SEQ_PWM_EN
    .bright(bright),
`endif
    .led_out(led_al), .tick_o(tick_al)
  );

  led_sequencer #(.LED_NUM(N), .CNT_MAX(25'd9), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk_50M(clk_50M), .rst_n(rst_n), .mode(mode), .mode_load(mode_load),
    .run(run), .step(step),
`ifdef LED_SEQ_PWM_EN
    .bright(bright),
`endif
    .led_out(led_ah), .tick_o(tick_ah)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pattern is a pure function of (mode, advances since load).
  int         m_cnt;
  int         m_idx;
  logic       m_tick;
  logic [1:0] m_mode;

  function automatic logic [N-1:0] exp_pat(input logic [1:0] md, input int idx);
    logic [N-1:0] one;
    logic [N-1:0] r;
    int p;
    one = 1;
    case (md)
      2'd0: r = one << (idx % N);
      2'd1: r = one << (N - 1 - (idx % N));
      2'd2: begin
        p = idx % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        r = one << p;
      end
      default: begin
        p = idx % (N + 1);
        r = N'((1 << p) - 1);
      end
    endcase
    return r;
  endfunction

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_idx  <= 0;
      m_tick <= 1'b0;
      m_mode <= 2'd0;
    end else if (mode_load) begin
      m_mode <= mode;
      m_idx  <= 0;
      m_cnt  <= 0;
      m_tick <= 1'b0;
    end else begin
      if (m_tick || (step && !run)) m_idx <= m_idx + 1;
      m_tick <= run && (m_cnt == CM);
      if (run) m_cnt <= (m_cnt == CM) ? 0 : m_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_leds(input string nm, input logic [N-1:0] pat);
    logic [N-1:0] inv;
    inv = ~pat;
    chk({nm, "_al"}, 16'(led_al), 16'(inv));
    chk({nm, "_ah"}, 16'(led_ah), 16'(pat));
  endtask

  task automatic chk_model(input string nm);
    chk_leds(nm, exp_pat(m_mode, m_idx));
    chk({nm, "_tick_al"}, 16'(tick_al), 16'(m_tick));
    chk({nm, "_tick_ah"}, 16'(tick_ah), 16'(m_tick));
  endtask

  typedef struct {
    logic         ml;
    logic [1:0]   md;
    logic         rn;
    logic         st;
    logic [N-1:0] pat;
  } vec_t;

  vec_t tbl[24];

  initial begin
    logic [N-1:0] saved;
    logic [N-1:0] e;
    bit           found;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 1'b0, 4'b0001};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0010};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0100};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b1000};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0100};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0010};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0001};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0010};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 1'b0, 4'b0010};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 1'b0, 4'b1000};
    tbl[10] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b0100};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b0010};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b0001};
    tbl[13] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b1000};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 4'b0000};
    tbl[15] = '{1'b0, 2'd3, 1'b0, 1'b1, 4'b0001};
    tbl[16] = '{1'b0, 2'd3, 1'b0, 1'b1, 4'b0011};
    tbl[17] = '{1'b0, 2'd3, 1'b0, 1'b1, 4'b0111};
    tbl[18] = '{1'b0, 2'd3, 1'b0, 1'b1, 4'b1111};
    tbl[19] = '{1'b0, 2'd3, 1'b0, 1'b1, 4'b0000};
    tbl[20] = '{1'b1, 2'd0, 1'b0, 1'b0, 4'b0001};
    tbl[21] = '{1'b0, 2'd0, 1'b0, 1'b1, 4'b0010};
    tbl[22] = '{1'b0, 2'd0, 1'b1, 1'b1, 4'b0010};
    tbl[23] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'b0010};

    // Reset values
    #25;
    chk_leds("reset", 4'b0001);
    chk("reset_tick", 16'(tick_al), 16'd0);
    @(negedge clk_50M);
    rst_n = 1'b1;

    // Paused table: mode loads and single steps
    for (int i = 0; i < 24; i++) begin
      mode_load = tbl[i].ml;
      mode      = tbl[i].md;
      run       = tbl[i].rn;
      step      = tbl[i].st;
      @(negedge clk_50M);
      chk_leds($sformatf("tbl%0d", i), tbl[i].pat);
      chk($sformatf("tbl%0d_tick", i), 16'(tick_al), 16'd0);
    end
    mode_load = 1'b0;
    step = 1'b0;

    // Free-running rotate left: changes every CNT_MAX+1 cycles, first at load+12
    mode = 2'd0;
    mode_load = 1'b1;
    run = 1'b1;
    @(negedge clk_50M);
    mode_load = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      e = exp_pat(2'd0, (i < 12) ? 0 : (i - 2) / 10);
      chk_leds($sformatf("run_c%0d", i), e);
      chk($sformatf("run_tick_c%0d", i), 16'(tick_al), 16'((i > 1) && (i % 10 == 1)));
      @(negedge clk_50M);
    end

    // Pause for 50 cycles
    run = 1'b0;
    saved = led_al;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_50M);
      chk("pause_led", 16'(led_al), 16'(saved));
      chk("pause_tick", 16'(tick_al), 16'd0);
    end
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      @(negedge clk_50M);
      step = 1'b0;
      chk_leds($sformatf("pause_step%0d", s), exp_pat(2'd0, 5 + s));
    end
    run = 1'b1;
    step = 1'b1;
    @(negedge clk_50M);
    step = 1'b0;
    run = 1'b0;
    chk_leds("step_while_run", exp_pat(2'd0, 7));

    // mode_load coincident with tick_o wins, no advance
    run = 1'b1;
    mode = 2'd2;
    mode_load = 1'b1;
    @(negedge clk_50M);
    mode_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tick_al) found = 1'b1;
      else @(negedge clk_50M);
    end
    chk("tick_wait", 16'(found), 16'd1);
    mode = 2'd1;
    mode_load = 1'b1;
    @(negedge clk_50M);
    mode_load = 1'b0;
    chk_leds("load_on_tick", 4'b1000);
    chk("load_on_tick_tick", 16'(tick_al), 16'd0);
    @(negedge clk_50M);
    chk_leds("load_on_tick_hold", 4'b1000);

    // Asynchronous reset mid-pattern
    repeat (25) @(negedge clk_50M);
    chk_leds("pre_reset", 4'b0010);
    rst_n = 1'b0;
    #2;
    chk_leds("async_reset", 4'b0001);
    chk("async_reset_tick", 16'(tick_al), 16'd0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    run = 1'b1;

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      mode_load = ($urandom_range(0, 39) == 0);
      mode      = 2'($urandom_range(0, 3));
      step      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) run = ~run;
      rst_n     = ($urandom_range(0, 799) != 0);
      @(negedge clk_50M);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
